// File: rtl/bnn_pkg.sv
// Shared helpers for the sequential binary neural network engine.
// Provides a constant-evaluable clog2, derived-width helpers for neuron
// records (threshold width and full record width) and the FSM state type.
package bnn_pkg;

  // Ceiling log2, usable in parameter/localparam expressions.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((33'd1 << i) < {1'b0, n}) r = i + 32'd1;
    end
    return r;
  endfunction

  // Threshold width for a neuron with n inputs: must hold popcount 0..n.
  function automatic int unsigned th_w(input int unsigned n);
    return clog2(n + 32'd1);
  endfunction

  // Record width: n weight bits followed by the threshold.
  function automatic int unsigned rec_w(input int unsigned n);
    return n + th_w(n);
  endfunction

  typedef enum logic [1:0] {
    StIdle,
    StHid,
    StOut
  } state_e;

endpackage

// File: rtl/bnn_neuron_eval.sv
// Single binary neuron evaluator, purely combinational.
// fire = popcount(w XNOR x) >= th (unsigned compare).
// Ports:
//   w    - N weight bits, w[i] pairs with x[i]
//   x    - N input bits
//   th   - threshold, th_w(N) bits; 0 always fires, > N never fires
//   fire - neuron output
module bnn_neuron_eval
  import bnn_pkg::*;
#(
  parameter int unsigned N = 8,
  localparam int unsigned TH = th_w(N)
) (
  input  logic [N-1:0]  w,
  input  logic [N-1:0]  x,
  input  logic [TH-1:0] th,
  output logic          fire
);

  logic [TH-1:0] cnt;

  always_comb begin
    cnt = '0;
    for (int i = 0; i < N; i++) begin
      cnt = cnt + TH'(w[i] ~^ x[i]);
    end
  end

  assign fire = (cnt >= th);

endmodule

// File: rtl/bnn_seq_engine.sv
// Time-multiplexed two-layer binary neural network.
// One neuron is evaluated per clock through a shared evaluator per layer:
// N_HID cycles for the hidden layer, then N_OUT cycles for the output layer.
// Weights/thresholds live in a serial scan chain P loaded while setup=1.
// Ports:
//   clk, rst_n          - clock, async active-low reset
//   setup               - shift the param chain, clear x, abort evaluation
//   param_in/param_out  - serial chain head / tail (P[L-1])
//   x_we/x_bank/x_data  - write one NIB-bit input bank while idle
//   start/busy/done     - evaluation handshake; done pulses when y updates
//   y                   - output layer result, holds between evaluations
module bnn_seq_engine
  import bnn_pkg::*;
#(
  parameter int unsigned N_IN  = 8,
  parameter int unsigned N_HID = 8,
  parameter int unsigned N_OUT = 8,
  parameter int unsigned NIB   = 4,
  localparam int unsigned NB   = N_IN / NIB,
  localparam int unsigned XB_W = (NB > 1) ? clog2(NB) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            setup,
  input  logic            param_in,
  output logic            param_out,
  input  logic            x_we,
  input  logic [XB_W-1:0] x_bank,
  input  logic [NIB-1:0]  x_data,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic [N_OUT-1:0] y
);

  localparam int unsigned TH_H    = th_w(N_IN);
  localparam int unsigned TH_O    = th_w(N_HID);
  localparam int unsigned R_H     = rec_w(N_IN);
  localparam int unsigned R_O     = rec_w(N_HID);
  localparam int unsigned L       = N_HID * R_H + N_OUT * R_O;
  localparam int unsigned IDX_MAX = (N_HID > N_OUT) ? N_HID : N_OUT;
  localparam int unsigned IDX_W   = (IDX_MAX > 1) ? clog2(IDX_MAX) : 1;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [L-1:0]     p_q, p_d;
  logic [N_IN-1:0]  x_q, x_d;
  logic [N_HID-1:0] hidden_q, hidden_d;
  logic [N_OUT-1:0] ybuf_q, ybuf_d;
  logic [N_OUT-1:0] y_q, y_d;
  logic             done_q, done_d;

  logic [R_H-1:0] rec_h;
  logic [R_O-1:0] rec_o;
  logic           fire_h, fire_o;

  // Select the record of the neuron currently addressed by idx.
  always_comb begin
    rec_h = '0;
    rec_o = '0;
    for (int k = 0; k < N_HID; k++) begin
      if (idx_q == IDX_W'(k)) rec_h = p_q[k*R_H +: R_H];
    end
    for (int k = 0; k < N_OUT; k++) begin
      if (idx_q == IDX_W'(k)) rec_o = p_q[N_HID*R_H + k*R_O +: R_O];
    end
  end

  bnn_neuron_eval #(.N(N_IN)) u_eval_hid (
    .w    (rec_h[N_IN-1:0]),
    .x    (x_q),
    .th   (rec_h[R_H-1 -: TH_H]),
    .fire (fire_h)
  );

  bnn_neuron_eval #(.N(N_HID)) u_eval_out (
    .w    (rec_o[N_HID-1:0]),
    .x    (hidden_q),
    .th   (rec_o[R_O-1 -: TH_O]),
    .fire (fire_o)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    p_d      = p_q;
    x_d      = x_q;
    hidden_d = hidden_q;
    ybuf_d   = ybuf_q;
    y_d      = y_q;
    done_d   = 1'b0;

    // Chain shifts in every state.
    if (setup) p_d = {p_q[L-2:0], param_in};

    if (setup) begin
      x_d = '0;
    end else if (x_we && (state_q == StIdle)) begin
      // Bank indices without a matching bank are silently dropped.
      for (int b = 0; b < NB; b++) begin
        if (x_bank == XB_W'(b)) x_d[b*NIB +: NIB] = x_data;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (start && !setup) begin
          state_d = StHid;
          idx_d   = '0;
        end
      end
      StHid: begin
        for (int k = 0; k < N_HID; k++) begin
          if (idx_q == IDX_W'(k)) hidden_d[k] = fire_h;
        end
        if (idx_q == IDX_W'(N_HID - 1)) begin
          state_d = StOut;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      StOut: begin
        for (int k = 0; k < N_OUT; k++) begin
          if (idx_q == IDX_W'(k)) ybuf_d[k] = fire_o;
        end
        if (idx_q == IDX_W'(N_OUT - 1)) begin
          // Commit includes the bit evaluated this cycle.
          y_d     = ybuf_d;
          done_d  = 1'b1;
          state_d = StIdle;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      default: begin
        state_d = StIdle;
        idx_d   = '0;
      end
    endcase

    // Abort: drop the in-flight evaluation, keep the previous y.
    if (setup && (state_q != StIdle)) begin
      state_d = StIdle;
      idx_d   = '0;
      y_d     = y_q;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      p_q      <= '0;
      x_q      <= '0;
      hidden_q <= '0;
      ybuf_q   <= '0;
      y_q      <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      p_q      <= p_d;
      x_q      <= x_d;
      hidden_q <= hidden_d;
      ybuf_q   <= ybuf_d;
      y_q      <= y_d;
      done_q   <= done_d;
    end
  end

  assign param_out = p_q[L-1];
  assign busy      = (state_q != StIdle);
  assign done      = done_q;
  assign y         = y_q;

endmodule

// File: tb/tb_bnn_seq_engine.sv
// Self-checking bench for bnn_seq_engine (defaults 8/8/8/4, L=192).
// Expected y values come from a bench-side model of the param chain and are
// queued when start is driven; a monitor pops and compares on each done.
module tb_bnn_seq_engine;

  localparam int N_IN   = 8;
  localparam int N_HID  = 8;
  localparam int N_OUT  = 8;
  localparam int NIB    = 4;
  localparam int TH_H   = 4;
  localparam int TH_O   = 4;
  localparam int R_H    = N_IN + TH_H;
  localparam int R_O    = N_HID + TH_O;
  localparam int L      = N_HID * R_H + N_OUT * R_O;
  localparam int LAT    = N_HID + N_OUT;
  localparam int BUDGET = 40;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             setup;
  logic             param_in;
  logic             param_out;
  logic             x_we;
  logic             x_bank;
  logic [NIB-1:0]   x_data;
  logic             start;
  logic             busy;
  logic             done;
  logic [N_OUT-1:0] y;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  logic [N_OUT-1:0] sb[$];
  logic [N_OUT-1:0] mon_exp;
  logic [L-1:0]     pm;
  logic [N_IN-1:0]  x_sh;
  logic [N_IN-1:0]  hw[N_HID];
  logic [TH_H-1:0]  hth[N_HID];
  logic [N_HID-1:0] ow[N_OUT];
  logic [TH_O-1:0]  oth[N_OUT];

  always #5 clk = ~clk;

  bnn_seq_engine #(
    .N_IN  (N_IN),
    .N_HID (N_HID),
    .N_OUT (N_OUT),
    .NIB   (NIB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .setup     (setup),
    .param_in  (param_in),
    .param_out (param_out),
    .x_we      (x_we),
    .x_bank    (x_bank),
    .x_data    (x_data),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .y         (y)
  );

  // Scoreboard consumer.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      done_cnt++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_done: got done with y=%h, expected no done", y);
      end else begin
        mon_exp = sb.pop_front();
        if (y !== mon_exp) begin
          errors++;
          $display("FAIL sb_y: got y=%h, expected %h", y, mon_exp);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected simulation to complete");
    $fatal(1);
  end

  function automatic logic [N_OUT-1:0] model_y(input logic [L-1:0] p,
                                               input logic [N_IN-1:0] xv);
    logic [N_HID-1:0] hid;
    logic [N_OUT-1:0] res;
    logic [R_H-1:0]   rh;
    logic [R_O-1:0]   ro;
    int cnt;
    for (int k = 0; k < N_HID; k++) begin
      rh = p[k*R_H +: R_H];
      cnt = 0;
      for (int i = 0; i < N_IN; i++) cnt += (rh[i] == xv[i]) ? 1 : 0;
      hid[k] = (cnt >= int'(rh[R_H-1 -: TH_H]));
    end
    for (int j = 0; j < N_OUT; j++) begin
      ro = p[N_HID*R_H + j*R_O +: R_O];
      cnt = 0;
      for (int i = 0; i < N_HID; i++) cnt += (ro[i] == hid[i]) ? 1 : 0;
      res[j] = (cnt >= int'(ro[R_O-1 -: TH_O]));
    end
    return res;
  endfunction

  task automatic shift_in(input logic [L-1:0] v);
    for (int i = L - 1; i >= 0; i--) begin
      @(negedge clk);
      setup = 1'b1;
      param_in = v[i];
      pm = {pm[L-2:0], v[i]};
      x_sh = '0;
    end
    @(negedge clk);
    setup = 1'b0;
    param_in = 1'b0;
  endtask

  task automatic load_arrays();
    logic [L-1:0] v;
    v = '0;
    for (int k = 0; k < N_HID; k++) begin
      v[k*R_H +: N_IN] = hw[k];
      v[k*R_H + N_IN +: TH_H] = hth[k];
    end
    for (int j = 0; j < N_OUT; j++) begin
      v[N_HID*R_H + j*R_O +: N_HID] = ow[j];
      v[N_HID*R_H + j*R_O + N_HID +: TH_O] = oth[j];
    end
    shift_in(v);
  endtask

  task automatic load_thermometer();
    for (int k = 0; k < N_HID; k++) begin hw[k] = '1; hth[k] = TH_H'(k + 1); end
    for (int j = 0; j < N_OUT; j++) begin ow[j] = '1; oth[j] = TH_O'(j + 1); end
    load_arrays();
  endtask

  task automatic write_x(input logic [N_IN-1:0] v);
    @(negedge clk);
    x_we = 1'b1; x_bank = 1'b0; x_data = v[3:0];
    @(negedge clk);
    x_bank = 1'b1; x_data = v[7:4];
    @(negedge clk);
    x_we = 1'b0;
    x_sh = v;
  endtask

  task automatic run_eval(input string name, input bit extra_start, input bit we_busy);
    int n;
    int bn;
    int dc0;
    sb.push_back(model_y(pm, x_sh));
    dc0 = done_cnt;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    bn = 0;
    while (n < BUDGET && done !== 1'b1) begin
      if (busy === 1'b1) bn++;
      if (n == 4) begin
        start = extra_start;
        x_we = we_busy; x_bank = 1'b0; x_data = 4'hF;
      end
      if (n == 5) begin start = 1'b0; x_we = 1'b0; end
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != LAT) begin
      errors++;
      $display("FAIL %s_latency: got %0d cycles to done, expected %0d", name, n, LAT);
      sb.delete();
    end
    checks++;
    if (bn != LAT) begin
      errors++;
      $display("FAIL %s_busy_cycles: got %0d, expected %0d", name, bn, LAT);
    end
    repeat (LAT + 4) @(negedge clk);
    checks++;
    if (done_cnt != dc0 + 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_done_count: got %0d dones busy=%b, expected 1 done busy=0",
               name, done_cnt - dc0, busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; setup = 1'b0; param_in = 1'b0; x_we = 1'b0; x_bank = 1'b0;
    x_data = '0; start = 1'b0; pm = '0; x_sh = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < L + 8; i++) begin
      @(negedge clk);
      setup = 1'b1;
      param_in = 1'b1;
    end
    @(negedge clk);
    checks++;
    if (param_out !== 1'b1) begin
      errors++;
      $display("FAIL reset_pre_param_out: got %b, expected 1", param_out);
    end
    #2 rst_n = 1'b0;
    #1;
    pm = '0; x_sh = '0;
    checks++;
    if (param_out !== 1'b0) begin
      errors++; $display("FAIL reset_param_out: got %b, expected 0", param_out);
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL reset_busy_done: got busy=%b done=%b, expected 0 0", busy, done);
    end
    checks++;
    if (y !== '0) begin
      errors++; $display("FAIL reset_y: got %h, expected 00", y);
    end
    @(negedge clk);
    setup = 1'b0; param_in = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_eval("reset_eval", 1'b0, 1'b0);
  endtask

  task automatic test_thermometer();
    load_thermometer();
    write_x(8'h07);
    run_eval("therm_07", 1'b0, 1'b0);
    write_x(8'hFF);
    run_eval("therm_ff", 1'b0, 1'b0);
    write_x(8'h00);
    run_eval("therm_00", 1'b0, 1'b0);
    write_x(8'h1F);
    run_eval("therm_1f", 1'b0, 1'b0);
  endtask

  task automatic test_chain();
    logic [L-1:0] v1;
    logic [L-1:0] got;
    for (int i = 0; i < L / 32; i++) v1[i*32 +: 32] = $urandom;
    shift_in(v1);
    for (int i = 0; i < L; i++) begin
      @(negedge clk);
      got[L-1-i] = param_out;
      setup = 1'b1;
      param_in = (i % 2 == 0);
      pm = {pm[L-2:0], (i % 2 == 0)};
      x_sh = '0;
    end
    @(negedge clk);
    setup = 1'b0;
    checks++;
    if (got !== v1) begin
      errors++;
      $display("FAIL chain_passthrough: got %h, expected %h", got, v1);
    end
    checks++;
    if (param_out !== 1'b1) begin
      errors++;
      $display("FAIL chain_tail: got %b, expected 1", param_out);
    end
  endtask

  task automatic test_never_fire();
    for (int k = 0; k < N_HID; k++) begin hw[k] = N_IN'($urandom); hth[k] = '1; end
    for (int j = 0; j < N_OUT; j++) begin ow[j] = N_HID'($urandom); oth[j] = '1; end
    load_arrays();
    write_x(8'hA5);
    run_eval("never_a5", 1'b0, 1'b0);
    write_x(8'hFF);
    run_eval("never_ff", 1'b0, 1'b0);
    for (int k = 0; k < N_HID; k++) begin hw[k] = '0; hth[k] = '0; end
    for (int j = 0; j < N_OUT; j++) begin ow[j] = '0; oth[j] = '0; end
    load_arrays();
    write_x(8'h5A);
    run_eval("always_5a", 1'b0, 1'b0);
  endtask

  task automatic test_abort();
    int dc0;
    load_thermometer();
    write_x(8'h07);
    run_eval("abort_prev", 1'b0, 1'b0);
    write_x(8'hFF);
    dc0 = done_cnt;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    setup = 1'b1;
    param_in = 1'b0;
    pm = {pm[L-2:0], 1'b0};
    x_sh = '0;
    @(negedge clk);
    setup = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL abort_busy: got %b, expected 0", busy);
    end
    repeat (LAT + 4) @(negedge clk);
    checks++;
    if (done_cnt != dc0) begin
      errors++; $display("FAIL abort_no_done: got %0d dones, expected 0", done_cnt - dc0);
    end
    checks++;
    if (y !== 8'h07) begin
      errors++; $display("FAIL abort_y_hold: got %h, expected 07", y);
    end
    run_eval("abort_after", 1'b0, 1'b0);
  endtask

  task automatic test_handshake();
    int dc0;
    int bn;
    load_thermometer();
    write_x(8'h3C);
    run_eval("start_busy", 1'b1, 1'b0);
    run_eval("we_busy", 1'b0, 1'b1);
    run_eval("we_after", 1'b0, 1'b0);
    dc0 = done_cnt;
    @(negedge clk);
    setup = 1'b1; start = 1'b1; param_in = 1'b0;
    pm = {pm[L-2:0], 1'b0};
    x_sh = '0;
    @(negedge clk);
    setup = 1'b0; start = 1'b0;
    bn = 0;
    for (int i = 0; i < LAT + 2; i++) begin
      if (busy !== 1'b0) bn++;
      @(negedge clk);
    end
    checks++;
    if (bn != 0 || done_cnt != dc0) begin
      errors++;
      $display("FAIL setup_start: got %0d busy cycles %0d dones, expected 0 0",
               bn, done_cnt - dc0);
    end
    run_eval("post_setup_start", 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_thermometer();
    test_chain();
    test_never_fire();
    test_abort();
    test_handshake();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
